stoch_signed_patch_scatter: RTL and testbench
=============================================

Name: stoch_signed_patch_scatter

Overview:
- Write-side counterpart of the patch extractor. It accepts one signed stochastic output pixel per handshake, with all channels carried as a p/m bit pair. Pixels arrive in raster order and are scattered into a registered HEIGHT x WIDTH x CHANNELS feature map.
- The block is double-buffered. A completed frame is presented on the output array, stable and valid, while the next frame fills. Sits after a conv/pool pixel engine and feeds the next layer's patch extractors.

Parameters:
- WIDTH, 32, output map columns (>=1)
- HEIGHT, 32, output map rows (>=1)
- CHANNELS, 3, bits per pixel per polarity (>=1)
- DEFAULT, 1'b0, reset/fill value of every map bit

Ports:
- CLK  input  1  clock, all state on rising edge
- nRST  input  1  asynchronous active-low reset
- restart  input  1  synchronous frame abort; fill counters return to (0,0)
- in_valid  input  1  pix_p/pix_m carry a pixel
- in_ready  output  1  block can accept a pixel this cycle
- pix_p  input  CHANNELS  positive stochastic bits for current pixel
- pix_m  input  CHANNELS  negative stochastic bits for current pixel
- out_p  output  [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0]  completed map, positive
- out_m  output  [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0]  completed map, negative
- out_valid  output  1  out_p/out_m hold a complete frame
- out_ack  input  1  consumer releases current frame
- row  output  clog2(HEIGHT) (min 1)  row index of next pixel to write
- col  output  clog2(WIDTH) (min 1)  column index of next pixel to write

Behaviour:
- Reset (nRST=0, asynchronous):
  - row=0, col=0, state=FILL, out_valid=0.
  - Every working-buffer and output-buffer bit is set to DEFAULT.
  - in_ready is 1 from the first cycle after reset release.
- States:
  - FILL: in_ready=1.
  - HOLD: working frame complete but output buffer still owned by consumer; in_ready=0.
  - in_ready is a combinational decode of state only; it does not depend on in_valid.
- Accept: accept = in_valid & in_ready.
  - On accept, working[row][col][c] takes pix_p[c] and pix_m[c] for all c. Bits are stored verbatim, with no p/m cancellation.
  - col then increments. At col=WIDTH-1, col wraps to 0 and row increments. At (HEIGHT-1, WIDTH-1), both wrap to 0.
- Output buffer free = !out_valid | out_ack.
- Frame completion: accept at (HEIGHT-1, WIDTH-1).
  - If the buffer is free on that edge, the output buffer loads the working buffer, with the final pixel merged in the same edge. out_valid=1 from the next cycle and state stays FILL, so the next frame may start immediately.
  - If the buffer is not free, state goes to HOLD and the working buffer is retained, including the last pixel.
- HOLD: on the edge where out_ack=1, the output buffer loads the working buffer, out_valid stays 1, and state returns to FILL.
- out_ack outside these cases:
  - With out_valid=1 and no frame completing, out_ack clears out_valid on the next cycle and leaves the output buffer contents unchanged.
  - out_ack while out_valid=0 is ignored.
- The output buffer changes only on a load edge. out_p/out_m are stable whenever out_valid=1 and no load occurs.
- restart:
  - Effect: row=col=0. In HOLD it also returns state to FILL and discards the pending frame, with no output load.
  - Priority: restart wins over a simultaneous accept, so that pixel is dropped. Output buffer and out_valid are unaffected.
  - Working buffer contents are not cleared; stale bits are overwritten by the new frame.
- Degenerate sizes: WIDTH=HEIGHT=1 means every accept completes a frame.
- Latency: 1 cycle from the final accept, or from the ack in HOLD, to updated out_p/out_m and out_valid.

Test Plan:
- H=2,W=3,C=2, reset then 6 accepts of pix_p=idx[1:0], pix_m=~idx[1:0] with no ack:
  - out_valid=1 one cycle after 6th accept.
  - out_p[1][2]=2'b01 (idx 5), out_p[0][0]=2'b00, out_m[0][1]=2'b10.
  - row/col back to 0/0.
- Same config, frame 1 valid and unacked, 6 more accepts (all pix_p=2'b11):
  - HOLD entered, in_ready=0, out_p still equals frame 1.
  - Assert out_ack: next cycle out_p all 2'b11, out_valid=1, in_ready=1.
- Frame valid, out_ack pulsed with no completion: out_valid=0 next cycle, out_p unchanged. Second out_ack while out_valid=0: no effect.
- Completion and out_ack on the same edge: new frame loaded, out_valid stays 1 with no dropout cycle.
- 3 accepts then restart together with in_valid: that pixel is dropped, row=col=0. Next 6 accepts produce a correct frame with no stale data visible.
- nRST asserted mid-frame and in HOLD: immediately out_valid=0, all out bits DEFAULT, row=col=0. in_ready=1 after release.

Source files
------------

// File: rtl/stoch_signed_patch_scatter.sv
// stoch_signed_patch_scatter
//   Collects signed stochastic pixels (p/m bit pairs) in raster order into a
//   HEIGHT x WIDTH x CHANNELS working map. Completed frames go to a second,
//   output-side map that stays stable while the next frame fills.
//
// Ports
//   CLK, nRST         clock, asynchronous active-low reset
//   restart           synchronous frame abort (fill position back to 0,0)
//   in_valid/in_ready pixel handshake; pix_p/pix_m carry the pixel
//   out_p/out_m       completed map, out_valid marks it as held
//   out_ack           consumer releases the held frame
//   row/col           position the next accepted pixel is written to
module stoch_signed_patch_scatter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned HEIGHT   = 32,
  parameter int unsigned CHANNELS = 3,
  parameter logic        DEFAULT  = 1'b0,
  localparam int unsigned RW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int unsigned CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                                      CLK,
  input  logic                                      nRST,
  input  logic                                      restart,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [CHANNELS-1:0]                       pix_p,
  input  logic [CHANNELS-1:0]                       pix_m,
  output logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0] out_p,
  output logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0] out_m,
  output logic                                      out_valid,
  input  logic                                      out_ack,
  output logic [RW-1:0]                             row,
  output logic [CW-1:0]                             col
);

  localparam int unsigned NB = HEIGHT * WIDTH * CHANNELS;

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          out_valid_q, out_valid_d;

  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0] work_p_q, work_p_d;
  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0] work_m_q, work_m_d;
  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0] obuf_p_q, obuf_p_d;
  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0] obuf_m_q, obuf_m_d;

  logic accept, last_col, last_pix, complete, buf_free, load;

  assign in_ready = (state_q == StFill);
  // restart has priority: a pixel presented alongside it is dropped
  assign accept   = in_valid & in_ready & ~restart;
  assign last_col = (col_q == CW'(WIDTH - 1));
  assign last_pix = last_col & (row_q == RW'(HEIGHT - 1));
  assign complete = accept & last_pix;
  assign buf_free = ~out_valid_q | out_ack;
  assign load     = (complete & buf_free) |
                    ((state_q == StHold) & out_ack & ~restart);

  always_comb begin
    work_p_d = work_p_q;
    work_m_d = work_m_q;
    if (accept) begin
      for (int r = 0; r < int'(HEIGHT); r++) begin
        for (int c = 0; c < int'(WIDTH); c++) begin
          if (row_q == RW'(r) && col_q == CW'(c)) begin
            work_p_d[r][c] = pix_p;
            work_m_d[r][c] = pix_m;
          end
        end
      end
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (restart) begin
      row_d = '0;
      col_d = '0;
    end else if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_pix ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = StFill;
    end else if (complete && !buf_free) begin
      state_d = StHold;
    end else if (state_q == StHold && out_ack) begin
      state_d = StFill;
    end
  end

  // Loading from the _d working map merges the final pixel on the completing edge;
  // in HOLD no accept happens, so _d equals the retained working map.
  always_comb begin
    obuf_p_d    = obuf_p_q;
    obuf_m_d    = obuf_m_q;
    out_valid_d = out_valid_q;
    if (load) begin
      obuf_p_d    = work_p_d;
      obuf_m_d    = work_m_d;
      out_valid_d = 1'b1;
    end else if (out_ack) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StFill;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      work_p_q    <= {NB{DEFAULT}};
      work_m_q    <= {NB{DEFAULT}};
      obuf_p_q    <= {NB{DEFAULT}};
      obuf_m_q    <= {NB{DEFAULT}};
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      work_p_q    <= work_p_d;
      work_m_q    <= work_m_d;
      obuf_p_q    <= obuf_p_d;
      obuf_m_q    <= obuf_m_d;
    end
  end

  assign out_p     = obuf_p_q;
  assign out_m     = obuf_m_q;
  assign out_valid = out_valid_q;
  assign row       = row_q;
  assign col       = col_q;

endmodule

// File: tb/tb_stoch_signed_patch_scatter.sv
// Scoreboard bench for stoch_signed_patch_scatter (2 x 3 map, 2 channels).
// Expected frames are queued as they are sent; a negedge monitor pops and
// compares each time a new frame appears on out_p/out_m with out_valid high.
module tb_stoch_signed_patch_scatter;

  localparam int H  = 2;
  localparam int W  = 3;
  localparam int C  = 2;
  localparam int NP = H * W;

  typedef logic [H-1:0][W-1:0][C-1:0] map_t;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       restart = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [C-1:0] pix_p = '0;
  logic [C-1:0] pix_m = '0;
  map_t       out_p, out_m;
  logic       out_valid;
  logic       out_ack = 1'b0;
  logic [0:0] row;
  logic [1:0] col;

  int checks = 0;
  int failures = 0;

  logic [2*H*W*C-1:0] sb[$];

  stoch_signed_patch_scatter #(
    .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .DEFAULT(1'b0)
  ) dut (
    .CLK(CLK), .nRST(nRST), .restart(restart), .in_valid(in_valid),
    .in_ready(in_ready), .pix_p(pix_p), .pix_m(pix_m), .out_p(out_p),
    .out_m(out_m), .out_valid(out_valid), .out_ack(out_ack), .row(row), .col(col)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: a newly presented frame is a rising out_valid or a content change while valid.
  logic prev_v = 1'b0;
  map_t prev_p = '0, prev_m = '0;
  always @(negedge CLK) begin
    if (out_valid === 1'b1 && (!prev_v || out_p !== prev_p || out_m !== prev_m)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_unexpected: got %h expected none at %0t", {out_p, out_m}, $time);
      end else begin
        check("frame", 32'({out_p, out_m}), 32'(sb.pop_front()));
      end
    end
    prev_v = out_valid;
    prev_p = out_p;
    prev_m = out_m;
  end

  function automatic void pat(input int k, input int idx, output logic [1:0] p,
                              output logic [1:0] m);
    logic [1:0] i2;
    i2 = idx[1:0];
    case (k)
      1: begin p = i2;             m = ~i2;          end
      2: begin p = 2'b11;          m = 2'b01;        end
      3: begin p = i2 + 2'd1;      m = ~i2;          end
      4: begin p = i2 ^ 2'b10;     m = 2'b10;        end
      5: begin p = {i2[0], i2[1]}; m = i2 + 2'd2;    end
      6: begin p = 2'b01;          m = 2'b11;        end
      default: begin p = 2'b10;    m = 2'b00;        end
    endcase
  endfunction

  task automatic drive_pix(input logic [1:0] p, input logic [1:0] m);
    pix_p    = p;
    pix_m    = m;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int k, input bit expect_load, input bit ack_last,
                            output map_t fp, output map_t fm);
    logic [1:0] p, m;
    fp = '0;
    fm = '0;
    for (int i = 0; i < NP; i++) begin
      pat(k, i, p, m);
      fp[i / W][i % W] = p;
      fm[i / W][i % W] = m;
      check("in_ready_fill", 32'(in_ready), 32'd1);
      if (ack_last && i == NP - 1) out_ack = 1'b1;
      drive_pix(p, m);
      out_ack = 1'b0;
    end
    if (expect_load) sb.push_back({fp, fm});
  endtask

  task automatic pulse_ack();
    out_ack = 1'b1;
    @(posedge CLK);
    #1;
    out_ack = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_outp"}, 32'(out_p), 32'd0);
    check({tag, "_outm"}, 32'(out_m), 32'd0);
    check({tag, "_row"}, 32'(row), 32'd0);
    check({tag, "_col"}, 32'(col), 32'd0);
  endtask

  map_t f1p, f1m, f2p, f2m, f3p, f3m, f4p, f4m, f5p, f5m, f6p, f6m, f7p, f7m;
  logic [1:0] tp, tm;

  initial begin
    #1;
    check_reset_state("rst0");
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Frame 1, no ack
    send_frame(1, 1'b1, 1'b0, f1p, f1m);
    check("f1_valid", 32'(out_valid), 32'd1);
    check("f1_p12", 32'(out_p[1][2]), 32'h1);
    check("f1_p00", 32'(out_p[0][0]), 32'h0);
    check("f1_m01", 32'(out_m[0][1]), 32'h2);
    check("f1_row", 32'(row), 32'd0);
    check("f1_col", 32'(col), 32'd0);

    // Frame 2 while frame 1 held -> HOLD
    send_frame(2, 1'b1, 1'b0, f2p, f2m);
    check("hold_ready", 32'(in_ready), 32'd0);
    check("hold_outp_f1", 32'(out_p), 32'(f1p));
    @(posedge CLK);
    #1;
    check("hold_outp_f1_later", 32'(out_p), 32'(f1p));
    check("hold_valid", 32'(out_valid), 32'd1);
    pulse_ack();
    check("hold_rel_valid", 32'(out_valid), 32'd1);
    check("hold_rel_ready", 32'(in_ready), 32'd1);
    check("hold_rel_outp", 32'(out_p), 32'(f2p));

    // Ack without completion clears valid; second ack ignored
    pulse_ack();
    check("ack_clr_valid", 32'(out_valid), 32'd0);
    check("ack_clr_outp", 32'(out_p), 32'(f2p));
    pulse_ack();
    check("ack_idle_valid", 32'(out_valid), 32'd0);
    check("ack_idle_outp", 32'(out_p), 32'(f2p));
    check("ack_idle_outm", 32'(out_m), 32'(f2m));

    // Frame 3 then frame 4 with ack on the completing edge
    send_frame(3, 1'b1, 1'b0, f3p, f3m);
    check("f3_valid", 32'(out_valid), 32'd1);
    send_frame(4, 1'b1, 1'b1, f4p, f4m);
    check("f4_valid", 32'(out_valid), 32'd1);
    check("f4_ready", 32'(in_ready), 32'd1);
    check("f4_outm", 32'(out_m), 32'(f4m));
    pulse_ack();
    check("f4_ack_valid", 32'(out_valid), 32'd0);

    // Partial frame, restart with a simultaneous pixel
    for (int i = 0; i < 3; i++) begin
      pat(7, i, tp, tm);
      drive_pix(tp, tm);
    end
    check("partial_col", 32'(col), 32'd0);
    check("partial_row", 32'(row), 32'd1);
    restart = 1'b1;
    drive_pix(2'b11, 2'b11);
    restart = 1'b0;
    check("restart_row", 32'(row), 32'd0);
    check("restart_col", 32'(col), 32'd0);
    check("restart_valid", 32'(out_valid), 32'd0);
    send_frame(5, 1'b1, 1'b0, f5p, f5m);
    check("f5_valid", 32'(out_valid), 32'd1);
    pulse_ack();

    // Reset mid-frame
    for (int i = 0; i < 2; i++) begin
      pat(6, i, tp, tm);
      drive_pix(tp, tm);
    end
    nRST = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_mid_ready", 32'(in_ready), 32'd1);

    // Reset while in HOLD
    send_frame(6, 1'b1, 1'b0, f6p, f6m);
    send_frame(7, 1'b0, 1'b0, f7p, f7m);
    check("hold2_ready", 32'(in_ready), 32'd0);
    nRST = 1'b0;
    #1;
    check_reset_state("rst_hold");
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_hold_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
